mult_arb: RTL and testbench
===========================

# mult_arb

Round-robin arbiter and sequencer that shares one shift-and-add multiplier (start/A/B/P/rdy handshake) among NREQ requesters. It accepts one operand pair at a time through per-requester valid/ready handshakes and drives the multiplier's start pulse and operands. It waits for the multiplier's completion and returns the product on a shared, tagged response bus. It sits between client blocks and the single multiplier instance, and both share clk and rst_b.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: watchdog limit in WAIT cycles; used only with the timeout feature.
- clk  in  1  system clock, rising edge.
- rst_b  in  1  reset; one clock, reset is asynchronous and active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a, req_b  in  NREQ x data_width  per-requester operands (packed array).
- req_ready  out  NREQ  one-hot grant/accept; a transfer occurs when req_valid[i] && req_ready[i].
- resp_valid  out  1  one-cycle pulse, result available.
- resp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- resp_p  out  2*data_width  product.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- m_start  out  1  multiplier start pulse.
- m_a, m_b  out  data_width  multiplier operands.
- m_p  in  2*data_width  multiplier product.
- m_rdy  in  1  multiplier done/idle.

## Operation
- States: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE
  - If any req_valid is set, combinationally assert req_ready for the round-robin winner only.
  - On the clock edge, latch the winner's operands into op_a/op_b, latch the winner index into cur_id, and go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- Round-robin: the search starts at ptr and wraps modulo NREQ. On accept, ptr <= winner+1 (with wrap).
- ISSUE: m_start=1 for exactly one cycle, with m_a/m_b = op_a/op_b. Go to SETTLE.
- SETTLE: ignore m_rdy, because the multiplier's rdy may still be high from idle. Go to WAIT.
- WAIT: when m_rdy=1, capture m_p into resp_p, set resp_err=0, and go to RESP.
- RESP: resp_valid=1 and resp_id=cur_id for one cycle. Go to IDLE.
- The response bus has no backpressure. Clients must sink the pulse.
- m_a/m_b hold op_a/op_b in all states. m_start is 0 outside ISSUE.
- req_ready is 0 in every state except IDLE. A new request is not accepted in the RESP cycle.
- Arithmetic: unsigned operands. resp_p is passed through unmodified at 2*data_width bits. The arbiter does no arithmetic.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_p=0, resp_err=0, m_start=0, m_a=0, m_b=0, and the timeout counter is 0.
- Reset mid-operation: all outputs return to reset values asynchronously and any in-flight result is discarded. The multiplier is reset by the same rst_b.
- Latency: accept edge -> m_start cycle = 1. m_rdy sampled high in WAIT -> resp_valid the next cycle.
- Total latency = 4 cycles + multiplier busy time.
- Back-to-back throughput: the earliest next accept is the cycle after RESP.
- Simultaneous requests: exactly one grant per IDLE cycle. Requesters that are not granted keep req_valid high and their operands stable until accepted.
- A req_valid drop before accept is legal and no grant is recorded for it.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with m_rdy still low, go to RESP with resp_err=1 and resp_p=0.
  - An m_rdy that arrives late after a timeout is ignored; the next m_start restarts the multiplier.
- MULT_ARB_TIMEOUT_EN undefined:
  - There is no counter and resp_err is tied 0.
  - WAIT holds indefinitely until m_rdy.

## Structure
- Package mult_arb_pkg:
  - state_t enum (IDLE, ISSUE, SETTLE, WAIT, RESP).
  - Default NREQ and TIMEOUT constants.
  - Operand width taken from the multiplier package's data_width.
- Sub-module rr_arb: combinational round-robin picker.
  - Inputs: req[NREQ] and ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - The ptr register stays in mult_arb.

## Test plan
- Requester 0, A=5, B=4, with a multiplier model: one accept, one m_start pulse with m_a=5 and m_b=4 -> resp_valid with resp_id=0, resp_p=0x14, resp_err=0.
- Requester 1, A=0xF, B=0xF -> resp_p=0xE1, resp_id=1. No second m_start is issued while in WAIT.
- All four req_valid held high from reset with distinct operands -> grants and responses in order 0,1,2,3, each response matching its own product, with no new grant between a grant and its RESP.
- Grant to requester 2, then requesters 0 and 3 pending -> next grants in order 3, then 0 (pointer wrap).
- rst_b low during WAIT -> all outputs 0 immediately, no resp_valid after release. A fresh request after release is served correctly.
- MULT_ARB_TIMEOUT_EN with m_rdy stuck low -> resp_valid with resp_err=1 and resp_p=0 exactly TIMEOUT cycles after entering WAIT. Without the macro: no response, and the arbiter is still in WAIT after 200 cycles.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state type and default sizing for the multiplier arbiter.
// data_width mirrors the operand width of the shared shift-and-add multiplier.
package mult_arb_pkg;

    localparam int data_width  = 8;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mult_arb_if.sv
// Request/response bus between clients and the arbiter, and the
// start/operand/product bus between the arbiter and the multiplier.
interface mult_arb_req_if import mult_arb_pkg::*; #(
    parameter int NREQ = NREQ_DEF
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0][data_width-1:0] req_a;
    logic [NREQ-1:0][data_width-1:0] req_b;
    logic [NREQ-1:0]                 req_ready;
    logic                            resp_valid;
    logic [IW-1:0]                   resp_id;
    logic [2*data_width-1:0]         resp_p;
    logic                            resp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_id, resp_p, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_id, resp_p, resp_err
    );
endinterface

interface mult_arb_mul_if import mult_arb_pkg::*;;
    logic                    m_start;
    logic [data_width-1:0]   m_a;
    logic [data_width-1:0]   m_b;
    logic [2*data_width-1:0] m_p;
    logic                    m_rdy;

    modport master (
        output m_start, m_a, m_b,
        input  m_p, m_rdy
    );

    modport slave (
        input  m_start, m_a, m_b,
        output m_p, m_rdy
    );
endinterface

// File: rtl/mult_arb_rr_arb.sv
// rr_arb: combinational round-robin picker; search starts at ptr and wraps.
// The pointer register itself lives in the parent.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_arb.sv
// mult_arb: round-robin sequencer sharing one multiplier among NREQ clients.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT watchdog that reports resp_err.
module mult_arb import mult_arb_pkg::*; #(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_b,
    mult_arb_req_if.slave  req,
    mult_arb_mul_if.master mul
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = 2 * data_width;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mult_arb: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    state_t                state;
    state_t                state_nx;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         cur_id;
    logic [IW-1:0]         gnt_idx;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ready;
    logic                  any;
    logic                  accept;
    logic                  start;
    logic                  resp_vld;
    logic                  expire;
    logic                  err;
    logic [data_width-1:0] op_a;
    logic [data_width-1:0] op_b;
    logic [PW-1:0]         prod;

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req     (req.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign accept = (state == IDLE) && any;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr    <= '0;
            cur_id <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else if (accept) begin
            op_a   <= req.req_a[gnt_idx];
            op_b   <= req.req_b[gnt_idx];
            cur_id <= gnt_idx;
            ptr    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prod <= '0;
        end else if (state == WAIT) begin
            if (mul.m_rdy) begin
                prod <= mul.m_p;
            end else if (expire) begin
                prod <= '0;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] cnt;

    assign expire = (state == WAIT) && !mul.m_rdy
                  && (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (state == SETTLE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err <= 1'b0;
        end else if (state == WAIT) begin
            if (mul.m_rdy) begin
                err <= 1'b0;
            end else if (expire) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // SETTLE exists because m_rdy may still read high from the idle multiplier
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        resp_vld = 1'b0;
        ready    = '0;
        unique case (state)
            IDLE: begin
                ready = rst_b ? gnt : '0;
                if (any) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                start    = 1'b1;
                state_nx = SETTLE;
            end
            SETTLE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (mul.m_rdy || expire) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_vld = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign req.req_ready  = ready;
    assign req.resp_valid = resp_vld;
    assign req.resp_id    = cur_id;
    assign req.resp_p     = prod;
    assign req.resp_err   = err;

    assign mul.m_start = start;
    assign mul.m_a     = op_a;
    assign mul.m_b     = op_b;

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: table vectors, directed corner sequences and random traffic
// checked against a transaction-level round-robin/product scoreboard.
module tb_mult_arb;
    import mult_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int DW = data_width;
    localparam int PW = 2 * DW;

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [PW-1:0] p;
    } vec_t;

    typedef struct {
        int            id;
        logic [PW-1:0] p;
        bit            err;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    mult_arb_req_if #(.NREQ(N)) rq();
    mult_arb_mul_if             mm();

    mult_arb #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .req   (rq),
        .mul   (mm)
    );

    int            checks    = 0;
    int            fails     = 0;
    int            cyc_no    = 0;
    int            n_resp    = 0;
    int            mul_lat   = 1;
    int            ptr_m     = 0;
    int            last_id   = -1;
    bit            stuck     = 1'b0;
    bit            mon_en    = 1'b0;
    bit            outst     = 1'b0;
    bit            start_due = 1'b0;
    bit            last_err  = 1'b0;
    logic [PW-1:0] last_p    = '0;
    logic [N-1:0]  vld       = '0;
    logic [DW-1:0] va [N];
    logic [DW-1:0] vb [N];
    logic [DW-1:0] sa;
    logic [DW-1:0] sb;
    exp_t          expq [$];
    int            grants [$];

    // Multiplier model: rdy drops one cycle after start, so it still reads
    // high (with a stale product) in the cycle right after start.
    logic          pend;
    int            mcnt;
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pend     <= 1'b0;
            mcnt     <= 0;
            ma       <= '0;
            mb       <= '0;
            mm.m_rdy <= 1'b1;
            mm.m_p   <= '0;
        end else if (mm.m_start) begin
            pend <= 1'b1;
            ma   <= mm.m_a;
            mb   <= mm.m_b;
        end else if (pend) begin
            pend     <= 1'b0;
            mm.m_rdy <= 1'b0;
            mcnt     <= mul_lat;
        end else if (!mm.m_rdy && !stuck) begin
            if (mcnt <= 1) begin
                mm.m_rdy <= 1'b1;
                mm.m_p   <= PW'(ma) * PW'(mb);
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc_no);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_ready"}, rq.req_ready, 0);
        chk({tag, " resp_valid"}, rq.resp_valid, 0);
        chk({tag, " resp_id"}, rq.resp_id, 0);
        chk({tag, " resp_p"}, rq.resp_p, 0);
        chk({tag, " resp_err"}, rq.resp_err, 0);
        chk({tag, " m_start"}, mm.m_start, 0);
        chk({tag, " m_a"}, mm.m_a, 0);
        chk({tag, " m_b"}, mm.m_b, 0);
    endtask

    // Round-robin rule: first valid requester at or after ptr_m, wrapping.
    function automatic int pick();
        int order [$];
        for (int k = ptr_m; k < N; k++) order.push_back(k);
        for (int k = 0; k < ptr_m; k++) order.push_back(k);
        foreach (order[k]) begin
            if (vld[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic monitor();
        logic [N-1:0] rdy;
        logic [N-1:0] g;
        exp_t         e;
        int           w;
        rdy = rq.req_ready;
        if (start_due) begin
            chk("m_start pulse", mm.m_start, 1);
            chk("m_a", mm.m_a, sa);
            chk("m_b", mm.m_b, sb);
            start_due = 1'b0;
        end else begin
            chk("m_start quiet", mm.m_start, 0);
        end
        if (outst) begin
            chk("no grant while busy", rdy, 0);
        end else if (vld == '0) begin
            chk("no grant when idle", rdy, 0);
        end else begin
            w    = pick();
            g    = '0;
            g[w] = 1'b1;
            chk("grant", rdy, g);
            e.id = w;
`ifdef MULT_ARB_TIMEOUT_EN
            e.p   = stuck ? '0 : PW'(va[w]) * PW'(vb[w]);
            e.err = stuck;
            e.due = stuck ? cyc_no + 3 + TO : cyc_no + 4 + mul_lat;
`else
            e.p   = PW'(va[w]) * PW'(vb[w]);
            e.err = 1'b0;
            e.due = stuck ? -1 : cyc_no + 4 + mul_lat;
`endif
            expq.push_back(e);
            grants.push_back(w);
            sa        = va[w];
            sb        = vb[w];
            start_due = 1'b1;
            outst     = 1'b1;
            ptr_m     = (w + 1) % N;
            vld[w]    = 1'b0;
        end
        if (rq.resp_valid) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious resp: got id %0d expected none",
                         rq.resp_id);
            end else begin
                e = expq.pop_front();
                chk("resp_id", rq.resp_id, e.id);
                chk("resp_p", rq.resp_p, e.p);
                chk("resp_err", rq.resp_err, e.err);
                chk("resp latency", cyc_no, e.due);
            end
            last_id  = int'(rq.resp_id);
            last_p   = rq.resp_p;
            last_err = rq.resp_err;
            n_resp++;
            outst = 1'b0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rq.req_valid = vld;
        for (int i = 0; i < N; i++) begin
            rq.req_a[i] = va[i];
            rq.req_b[i] = vb[i];
        end
        #1;
        cyc_no++;
        if (mon_en) monitor();
    endtask

    task automatic clear_model();
        vld          = '0;
        rq.req_valid = '0;
        expq.delete();
        grants.delete();
        outst     = 1'b0;
        start_due = 1'b0;
        ptr_m     = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b  = 1'b0;
        mon_en = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_b  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((vld != '0 || outst) && k < budget) begin
            cyc();
            k++;
        end
        if (vld != '0 || outst) begin
            checks++;
            fails++;
            $display("FAIL %s: still busy after %0d cycles, want idle",
                     tag, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [5];
        int   n0;
        int   g0;

        for (int i = 0; i < N; i++) begin
            va[i] = '0;
            vb[i] = '0;
            rq.req_a[i] = '1;
            rq.req_b[i] = '1;
        end
        #1;
        rst_b        = 1'b0;
        rq.req_valid = '1;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rq.req_valid = '0;
        rst_b        = 1'b1;
        mon_en       = 1'b1;

        tab[0] = '{id: 0, a: 8'h05, b: 8'h04, p: 16'h0014};
        tab[1] = '{id: 1, a: 8'h0F, b: 8'h0F, p: 16'h00E1};
        tab[2] = '{id: 3, a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        tab[3] = '{id: 2, a: 8'h00, b: 8'h07, p: 16'h0000};
        tab[4] = '{id: 1, a: 8'h80, b: 8'h02, p: 16'h0100};
        for (int i = 0; i < 5; i++) begin
            mul_lat          = 1 + i;
            n0               = n_resp;
            va[tab[i].id]    = tab[i].a;
            vb[tab[i].id]    = tab[i].b;
            vld[tab[i].id]   = 1'b1;
            wait_idle(100, "table");
            chk("table resp count", n_resp - n0, 1);
            chk("table resp_id", last_id, tab[i].id);
            chk("table resp_p", last_p, tab[i].p);
        end

        do_reset();
        mul_lat = 2;
        for (int i = 0; i < N; i++) begin
            va[i] = DW'(i + 3);
            vb[i] = DW'((i + 1) * 17);
        end
        vld = '1;
        wait_idle(200, "four");
        chk("four grant count", grants.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("four grant order", grants[k], k);
        end

        grants.delete();
        va[2]  = 8'h21;
        vb[2]  = 8'h03;
        vld[2] = 1'b1;
        wait_idle(100, "wrap first");
        va[0]  = 8'h10;
        vb[0]  = 8'h10;
        va[3]  = 8'h07;
        vb[3]  = 8'h09;
        vld[0] = 1'b1;
        vld[3] = 1'b1;
        wait_idle(100, "wrap pair");
        chk("wrap grant count", grants.size(), 3);
        chk("wrap grant 0", grants[0], 2);
        chk("wrap grant 1", grants[1], 3);
        chk("wrap grant 2", grants[2], 0);

        mul_lat = 20;
        va[1]   = 8'h09;
        vb[1]   = 8'h07;
        vld[1]  = 1'b1;
        g0      = 0;
        while (grants.size() < 4 && g0 < 20) begin
            cyc();
            g0++;
        end
        chk("mid reset grant seen", grants.size(), 4);
        va[3]  = 8'h05;
        vb[3]  = 8'h05;
        vld[3] = 1'b1;
        repeat (5) cyc();
        #2;
        rst_b  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk_zero("mid reset");
        clear_model();
        repeat (2) @(negedge clk);
        rst_b  = 1'b1;
        mon_en = 1'b1;
        n0     = n_resp;
        repeat (30) cyc();
        chk("no resp after reset", n_resp - n0, 0);
        mul_lat = 3;
        va[2]   = 8'd12;
        vb[2]   = 8'd11;
        vld[2]  = 1'b1;
        wait_idle(100, "post reset");
        chk("post reset resp_id", last_id, 2);
        chk("post reset resp_p", last_p, 16'd132);

        do_reset();
        n0 = n_resp;
        for (int t = 0; t < 1500; t++) begin
            if (!outst) mul_lat = int'($urandom_range(1, 6));
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 3) == 0) begin
                    va[i]  = DW'($urandom);
                    vb[i]  = DW'($urandom);
                    vld[i] = 1'b1;
                end else if (vld[i] && $urandom_range(0, 19) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            cyc();
        end
        wait_idle(300, "random drain");
        chk("random resp count", n_resp - n0, grants.size());

        do_reset();
        stuck   = 1'b1;
        mul_lat = 2;
        va[0]   = 8'h03;
        vb[0]   = 8'h03;
        vld[0]  = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_idle(TO + 50, "timeout");
        chk("timeout resp_err", last_err, 1);
        chk("timeout resp_p", last_p, 0);
        stuck  = 1'b0;
        va[1]  = 8'd6;
        vb[1]  = 8'd7;
        vld[1] = 1'b1;
        wait_idle(100, "after timeout");
        chk("after timeout resp_p", last_p, 16'd42);
        chk("after timeout resp_err", last_err, 0);
`else
        n0 = n_resp;
        repeat (3) cyc();
        va[3]  = 8'h02;
        vb[3]  = 8'h02;
        vld[3] = 1'b1;
        repeat (200) cyc();
        chk("stuck no resp", n_resp - n0, 0);
        chk("stuck still waiting", outst, 1);
        stuck = 1'b0;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
